// File: rtl/trig_expand_lut_if.sv
// trig_expand_lut_if
//   Sample-in / expansion-out bundle for the FLAF trigonometric expansion stage.
//   master : the upstream producer / downstream consumer side (drives samples).
//   slave  : the expansion stage itself (drives results).
//   Signals:
//     in_valid  new sample present on x_n this cycle
//     x_n       input sample, Q(WIDTH-QP-1).QP two's complement
//     out_valid expansion outputs hold a new result
//     x_d       x_n delayed to align with the trig outputs
//     s1 / c1   sin(pi*x) / cos(pi*x)
//     s2 / c2   sin(2*pi*x) / cos(2*pi*x)
interface trig_expand_lut_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] x_n;
    logic             out_valid;
    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] c1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] c2;

    modport master (
        output in_valid, x_n,
        input  out_valid, x_d, s1, c1, s2, c2
    );

    modport slave (
        input  in_valid, x_n,
        output out_valid, x_d, s1, c1, s2, c2
    );
endinterface

// File: rtl/trig_expand_lut.sv
// trig_expand_lut
//   Functional-link trigonometric expansion: for each input sample x produces
//   x delayed, sin/cos(pi*x) and sin/cos(2*pi*x) from a shared quarter-wave
//   sine ROM. Two-stage pipeline, one sample per clock, no backpressure.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset, clears every register
//     bus    trig_expand_lut_if.slave (in_valid/x_n in, out_valid/x_d/s1/c1/s2/c2 out)
//   Parameters:
//     WIDTH  data word width
//     QP     fractional bits (1.0 = 2^QP)
//     LUT_AW quarter-wave ROM address bits (ROM has 2^LUT_AW + 1 entries)
module trig_expand_lut #(
    parameter int WIDTH  = 16,
    parameter int QP     = 12,
    parameter int LUT_AW = 8
) (
    input  logic               clk,
    input  logic               reset,
    trig_expand_lut_if.slave   bus
);

    localparam int  N  = 1 << LUT_AW;
    localparam int  PB = LUT_AW + 2;
    localparam int  AW = LUT_AW + 1;
    localparam real PI = 3.14159265358979323846;
    localparam logic [AW-1:0] N_ADDR = AW'(N);

    // Elaboration-time ROM generator: Taylor series of sin on [0, pi/2],
    // rounded half-up (all entries are non-negative). The top entry is
    // pinned to exactly 1.0 so the quadrant boundaries give +/-2^QP.
    function automatic logic [WIDTH-1:0] lut_entry(input int unsigned k);
        real ang;
        real term;
        real acc;
        if (k == N) begin
            return WIDTH'(1 << QP);
        end
        ang  = real'(k) * PI / real'(2 * N);
        term = ang;
        acc  = ang;
        for (int unsigned n = 1; n <= 12; n++) begin
            term = -term * ang * ang / real'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        return WIDTH'($rtoi(acc * real'(1 << QP) + 0.5));
    endfunction

    logic [WIDTH-1:0] w_rom [0:N];

    for (genvar k = 0; k <= N; k++) begin : g_rom
        assign w_rom[k] = lut_entry(k);
    end

    // Output lane order: 0 = s1, 1 = c1, 2 = s2, 3 = c2.
    logic [PB-1:0]     w_p1;
    logic [PB-1:0]     w_p2;
    logic [1:0]        w_quad [4];
    logic [LUT_AW-1:0] w_idx  [4];
    logic [AW-1:0]     w_addr [4];
    logic [3:0]        w_neg;

    // Bits above the field are the periodic wrap, bits below are truncated.
    assign w_p1 = bus.x_n[QP   -: PB];
    assign w_p2 = bus.x_n[QP-1 -: PB];

    always_comb begin
        // Cosine is the sine one quadrant ahead.
        w_quad[0] = w_p1[PB-1:PB-2];
        w_quad[1] = w_p1[PB-1:PB-2] + 2'd1;
        w_quad[2] = w_p2[PB-1:PB-2];
        w_quad[3] = w_p2[PB-1:PB-2] + 2'd1;
        w_idx[0]  = w_p1[LUT_AW-1:0];
        w_idx[1]  = w_p1[LUT_AW-1:0];
        w_idx[2]  = w_p2[LUT_AW-1:0];
        w_idx[3]  = w_p2[LUT_AW-1:0];
        w_neg     = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            // Odd quadrants read the ROM mirrored; i=0 there lands on L[N].
            w_addr[j] = w_quad[j][0] ? (N_ADDR - {1'b0, w_idx[j]})
                                     : {1'b0, w_idx[j]};
            w_neg[j]  = w_quad[j][1];
        end
    end

    // Stage 1: folded addresses, negate flags, valid, sample.
    logic [AW-1:0]    r_addr [4];
    logic [3:0]       r_neg;
    logic             r_vld1;
    logic [WIDTH-1:0] r_x1;

    // Stage 2: signed ROM data, valid, aligned sample.
    logic [WIDTH-1:0] r_out [4];
    logic             r_vld2;
    logic [WIDTH-1:0] r_x2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned j = 0; j < 4; j++) begin
                r_addr[j] <= '0;
                r_out[j]  <= '0;
            end
            r_neg  <= '0;
            r_vld1 <= 1'b0;
            r_x1   <= '0;
            r_vld2 <= 1'b0;
            r_x2   <= '0;
        end else begin
            for (int unsigned j = 0; j < 4; j++) begin
                r_addr[j] <= w_addr[j];
                r_out[j]  <= r_neg[j] ? (-w_rom[r_addr[j]]) : w_rom[r_addr[j]];
            end
            r_neg  <= w_neg;
            r_vld1 <= bus.in_valid;
            r_x1   <= bus.x_n;
            r_vld2 <= r_vld1;
            r_x2   <= r_x1;
        end
    end

    assign bus.out_valid = r_vld2;
    assign bus.x_d       = r_x2;
    assign bus.s1        = r_out[0];
    assign bus.c1        = r_out[1];
    assign bus.s2        = r_out[2];
    assign bus.c2        = r_out[3];

endmodule

// File: tb/tb_trig_expand_lut.sv
// tb_trig_expand_lut
//   Scoreboard bench for trig_expand_lut: stimulus pushes expected results
//   (exact constants for the landmark angles, a floating-point sin/cos model
//   of the truncated phase otherwise); a negedge monitor pops and compares
//   each out_valid result, including its arrival cycle.
module tb_trig_expand_lut;

    localparam int  WIDTH  = 16;
    localparam int  QP     = 12;
    localparam int  LUT_AW = 8;
    localparam int  PB     = LUT_AW + 2;
    localparam real PI     = 3.14159265358979323846;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    trig_expand_lut_if #(.WIDTH(WIDTH)) bus ();

    trig_expand_lut #(
        .WIDTH (WIDTH),
        .QP    (QP),
        .LUT_AW(LUT_AW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [15:0] x;
        int          s1;
        int          c1;
        int          s2;
        int          c2;
        bit          exact;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Phase = x*order/2 turns, quantised to PB bits by flooring, then an
    // ideal sin/cos rounded half away from zero.
    function automatic int ref_trig(input logic [15:0] x, input int order, input bit cosine);
        int  xi;
        int  p;
        real ang;
        real v;
        xi  = int'($signed(x));
        p   = ((xi * order) >>> (QP + 1 - PB)) & ((1 << PB) - 1);
        ang = 2.0 * PI * real'(p) / real'(1 << PB);
        v   = (cosine ? $cos(ang) : $sin(ang)) * real'(1 << QP);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    task automatic check(input string name, input int act, input int exp, input int tol);
        n_cmp++;
        if ((act - exp > tol) || (exp - act > tol)) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
        end
    endtask

    // Drive one cycle of input (called at posedge+1), record expectation.
    task automatic send(input logic [15:0] x, input bit vld, input bit use_exact,
                        input int es1, input int ec1, input int es2, input int ec2);
        exp_t e;
        bus.in_valid = vld;
        bus.x_n      = x;
        if (vld) begin
            e.x     = x;
            e.exact = use_exact;
            e.cyc   = cyc;
            if (use_exact) begin
                e.s1 = es1; e.c1 = ec1; e.s2 = es2; e.c2 = ec2;
            end else begin
                e.s1 = ref_trig(x, 1, 1'b0);
                e.c1 = ref_trig(x, 1, 1'b1);
                e.s2 = ref_trig(x, 2, 1'b0);
                e.c2 = ref_trig(x, 2, 1'b1);
            end
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, int'(bus.out_valid), 0, 0);
        check({tag, "_x_d"}, int'($signed(bus.x_d)), 0, 0);
        check({tag, "_s1"},  int'($signed(bus.s1)),  0, 0);
        check({tag, "_c1"},  int'($signed(bus.c1)),  0, 0);
        check({tag, "_s2"},  int'($signed(bus.s2)),  0, 0);
        check({tag, "_c2"},  int'($signed(bus.c2)),  0, 0);
    endtask

    // Monitor: every out_valid must match the oldest outstanding expectation,
    // arriving exactly two cycles after it was issued.
    always @(negedge clk) begin
        exp_t e;
        int   tol;
        if (!reset && bus.out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out_valid: got 1 expected 0 at cycle %0d", cyc);
            end else begin
                e   = sbq.pop_front();
                tol = e.exact ? 0 : 1;
                check("latency", cyc, e.cyc + 2, 0);
                check("x_d", int'($signed(bus.x_d)), int'($signed(e.x)), 0);
                check("s1",  int'($signed(bus.s1)),  e.s1, tol);
                check("c1",  int'($signed(bus.c1)),  e.c1, tol);
                check("s2",  int'($signed(bus.s2)),  e.s2, tol);
                check("c2",  int'($signed(bus.c2)),  e.c2, tol);
            end
        end
    end

    logic [15:0] dx [6] = '{16'h0000, 16'h0400, 16'h0800, 16'hF800, 16'h1000, 16'h8000};
    int          dv [6][4] = '{'{0, 4096, 0, 4096},
                               '{2896, 2896, 4096, 0},
                               '{4096, 0, 0, -4096},
                               '{-4096, 0, 0, -4096},
                               '{0, -4096, 0, 4096},
                               '{0, 4096, 0, 4096}};

    initial begin
        int ghosts;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.x_n      = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Landmark angles, isolated so out_valid must be a single-cycle pulse.
        for (int i = 0; i < 6; i++) begin
            send(dx[i], 1'b1, 1'b1, dv[i][0], dv[i][1], dv[i][2], dv[i][3]);
            repeat (3) send(16'h0000, 1'b0, 1'b0, 0, 0, 0, 0);
        end

        // Same landmarks back-to-back.
        for (int i = 0; i < 6; i++)
            send(dx[i], 1'b1, 1'b1, dv[i][0], dv[i][1], dv[i][2], dv[i][3]);

        // Random sweep with randomly gapped in_valid.
        for (int i = 0; i < 10000; i++)
            send(16'($urandom()), ($urandom_range(0, 9) < 7), 1'b0, 0, 0, 0, 0);
        send(16'h0000, 1'b0, 1'b0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 4; i++)
            send(16'($urandom()), 1'b1, 1'b0, 0, 0, 0, 0);
        bus.in_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check_zero_outputs("rst_async");
        sbq.delete();
        @(posedge clk);
        #2;
        reset = 1'b0;
        ghosts = 0;
        repeat (6) begin
            @(negedge clk);
            ghosts += int'(bus.out_valid);
        end
        check("no_ghost_after_reset", ghosts, 0, 0);
        @(posedge clk);
        #1;

        // First post-reset sample.
        send(16'h0400, 1'b1, 1'b1, 2896, 2896, 4096, 0);
        send(16'h0000, 1'b0, 1'b0, 0, 0, 0, 0);

        for (int k = 0; k < 10 && sbq.size() != 0; k++) @(posedge clk);
        #1;
        check("queue_drain", sbq.size(), 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
